// File: rtl/bridge_req_pkg.sv
// Shared types and sizing helpers for the request-side bridge.
package bridge_req_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned AUX_W  = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] add;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic [AUX_W-1:0]  aux;
  } req_payload_t;

  function automatic int unsigned log_slave(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/outstanding_ctr_bridge.sv
// Saturating up/down in-flight counter; flags a decrement seen while empty.
module outstanding_ctr_bridge
  import bridge_req_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 4,
  parameter int unsigned CNT_W     = cnt_width(MAX_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      // err stays set until reset once an unmatched response is seen
      if (dec && (cnt == '0)) err <= 1'b1;
      case ({inc, dec})
        2'b10:   if (cnt != CNT_W'(MAX_COUNT)) cnt <= cnt + CNT_W'(1);
        2'b01:   if (cnt != '0) cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/request_fanout_bridge.sv
// Routes one master request channel to N_SLAVE targets through a registered
// stage, limiting in-flight requests and holding target switches until drained.
module request_fanout_bridge
  import bridge_req_pkg::*;
#(
  parameter int unsigned N_SLAVE         = 16,
  parameter int unsigned ADDR_WIDTH      = ADDR_W,
  parameter int unsigned DATA_WIDTH      = DATA_W,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned AUX_WIDTH       = AUX_W,
  parameter int unsigned ROUTE_LSB       = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                 data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]  data_be_i,
  input  logic [AUX_WIDTH-1:0] data_aux_i,
  output logic                 data_gnt_o,
  input  logic                 data_r_valid_i,
  output logic [N_SLAVE-1:0]   data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                 data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]  data_be_o,
  output logic [AUX_WIDTH-1:0] data_aux_o,
  input  logic [N_SLAVE-1:0]   data_gnt_i,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0] outstanding_o,
  output logic                 err_unexp_rsp_o
);

  localparam int unsigned LOG_SLAVE = log_slave(N_SLAVE);
  localparam int unsigned CNT_W     = cnt_width(MAX_OUTSTANDING);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic [AUX_WIDTH-1:0]  aux;
  } payload_t;

  logic                 out_valid;
  logic [LOG_SLAVE-1:0] out_tgt;
  logic [LOG_SLAVE-1:0] last_tgt;
  payload_t             out_pl;
  logic [CNT_W-1:0]     cnt;

  logic [LOG_SLAVE-1:0] tgt_in;
  logic                 out_fire;
  logic                 can_load;
  logic                 allowed;
  logic                 accept;

  assign tgt_in   = data_add_i[ROUTE_LSB +: LOG_SLAVE];
  assign out_fire = out_valid & data_gnt_i[out_tgt];
  assign can_load = !out_valid | out_fire;
  // Same-target-only while busy keeps responses returning in request order
  assign allowed  = (cnt < CNT_W'(MAX_OUTSTANDING)) & ((cnt == '0) | (tgt_in == last_tgt));
  assign accept   = data_req_i & can_load & allowed & !rst;

  assign data_gnt_o = accept;

  // Output stage: loads on accept, empties when the selected target grants
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tgt   <= '0;
      last_tgt  <= '0;
      out_pl    <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_tgt      <= tgt_in;
      last_tgt     <= tgt_in;
      out_pl.add   <= data_add_i;
      out_pl.wen   <= data_wen_i;
      out_pl.wdata <= data_wdata_i;
      out_pl.be    <= data_be_i;
      out_pl.aux   <= data_aux_i;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  always_comb begin
    data_req_o          = '0;
    data_req_o[out_tgt] = out_valid;
  end

  assign data_add_o   = out_pl.add;
  assign data_wen_o   = out_pl.wen;
  assign data_wdata_o = out_pl.wdata;
  assign data_be_o    = out_pl.be;
  assign data_aux_o   = out_pl.aux;

  outstanding_ctr_bridge #(
    .MAX_COUNT (MAX_OUTSTANDING),
    .CNT_W     (CNT_W)
  ) u_ctr (
    .clk (clk),
    .rst (rst),
    .inc (accept),
    .dec (data_r_valid_i),
    .cnt (cnt),
    .err (err_unexp_rsp_o)
  );

  assign outstanding_o = cnt;

endmodule

// File: tb/tb_request_fanout_bridge.sv
// Directed bench for request_fanout_bridge with default parameters.
module tb_request_fanout_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req_i;
  logic [31:0] data_add_i;
  logic        data_wen_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic [7:0]  data_aux_i;
  logic        data_gnt_o;
  logic        data_r_valid_i;
  logic [15:0] data_req_o;
  logic [31:0] data_add_o;
  logic        data_wen_o;
  logic [31:0] data_wdata_o;
  logic [3:0]  data_be_o;
  logic [7:0]  data_aux_o;
  logic [15:0] data_gnt_i;
  logic [2:0]  outstanding_o;
  logic        err_unexp_rsp_o;

  int checks = 0;
  int errors = 0;

  request_fanout_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .data_req_i      (data_req_i),
    .data_add_i      (data_add_i),
    .data_wen_i      (data_wen_i),
    .data_wdata_i    (data_wdata_i),
    .data_be_i       (data_be_i),
    .data_aux_i      (data_aux_i),
    .data_gnt_o      (data_gnt_o),
    .data_r_valid_i  (data_r_valid_i),
    .data_req_o      (data_req_o),
    .data_add_o      (data_add_o),
    .data_wen_o      (data_wen_o),
    .data_wdata_o    (data_wdata_o),
    .data_be_o       (data_be_o),
    .data_aux_o      (data_aux_o),
    .data_gnt_i      (data_gnt_i),
    .outstanding_o   (outstanding_o),
    .err_unexp_rsp_o (err_unexp_rsp_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] addr_of(input int tgt, input int idx);
    return 32'((idx << 8) | (tgt << 2));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [31:0] add, input logic [31:0] wd, input logic rv);
    data_req_i     = req;
    data_add_i     = add;
    data_wdata_i   = wd;
    data_wen_i     = 1'b1;
    data_be_i      = 4'hF;
    data_aux_i     = add[15:8];
    data_r_valid_i = rv;
    #2;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      drive(1'b0, '0, '0, 1'b1);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (outstanding_o !== 3'd0) begin
      errors++; $display("FAIL drain_cnt: got %0d expected 0", outstanding_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_gnt_i = '1;
    drive(1'b1, addr_of(3, 0), 32'h0, 1'b0);
    tick(); tick();
    #2;
    checks++;
    if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", data_gnt_o); end
    checks++;
    if (data_req_o !== 16'h0) begin errors++; $display("FAIL reset_req: got %h expected 0000", data_req_o); end
    checks++;
    if (outstanding_o !== 3'd0 || err_unexp_rsp_o !== 1'b0 || data_add_o !== 32'h0) begin
      errors++; $display("FAIL reset_state: cnt %0d err %b add %h expected 0 0 0", outstanding_o, err_unexp_rsp_o, data_add_o);
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    data_gnt_i = '1;
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'b1, addr_of(3, i + 1), 32'(i + 100), 1'b0);
      checks++;
      if (data_gnt_o !== 1'b1 || outstanding_o !== 3'(i)) begin
        errors++; $display("FAIL b2b_gnt[%0d]: gnt %b cnt %0d expected 1 %0d", i, data_gnt_o, outstanding_o, i);
      end
      if (i > 0) begin
        checks++;
        if (data_req_o !== 16'h0008 || data_add_o !== addr_of(3, i) || data_wdata_o !== 32'(i + 99)) begin
          errors++; $display("FAIL b2b_out[%0d]: req %h add %h wd %h expected 0008 %h %h",
                             i, data_req_o, data_add_o, data_wdata_o, addr_of(3, i), 32'(i + 99));
        end
      end
    end
    tick();
    drive(1'b1, addr_of(3, 9), 32'h9, 1'b0);
    checks++;
    if (data_gnt_o !== 1'b0 || outstanding_o !== 3'd4) begin
      errors++; $display("FAIL b2b_full: gnt %b cnt %0d expected 0 4", data_gnt_o, outstanding_o);
    end
    checks++;
    if (data_req_o !== 16'h0008 || data_add_o !== addr_of(3, 4) || data_aux_o !== 8'h04) begin
      errors++; $display("FAIL b2b_last: req %h add %h aux %h expected 0008 %h 04", data_req_o, data_add_o, data_aux_o, addr_of(3, 4));
    end
    drain(4);
    checks++;
    if (data_req_o !== 16'h0) begin errors++; $display("FAIL b2b_empty: req %h expected 0000", data_req_o); end
  endtask

  task automatic test_hold();
    data_gnt_i = 16'hFFF7;
    tick();
    drive(1'b1, addr_of(3, 10), 32'hA0, 1'b0);
    checks++;
    if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL hold_first: gnt %b expected 1", data_gnt_o); end
    for (int k = 0; k < 5; k++) begin
      tick();
      drive(1'b1, addr_of(3, 11), 32'hB0, 1'b0);
      checks++;
      if (data_gnt_o !== 1'b0 || data_req_o !== 16'h0008 || data_add_o !== addr_of(3, 10) || data_wdata_o !== 32'hA0) begin
        errors++; $display("FAIL hold[%0d]: gnt %b req %h add %h wd %h expected 0 0008 %h a0",
                           k, data_gnt_o, data_req_o, data_add_o, data_wdata_o, addr_of(3, 10));
      end
    end
    data_gnt_i = '1;
    #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL hold_release: gnt %b expected 1", data_gnt_o); end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (data_req_o !== 16'h0008 || data_add_o !== addr_of(3, 11) || outstanding_o !== 3'd2) begin
      errors++; $display("FAIL hold_next: req %h add %h cnt %0d expected 0008 %h 2", data_req_o, data_add_o, outstanding_o, addr_of(3, 11));
    end
    drain(2);
  endtask

  task automatic test_switch();
    data_gnt_i = '1;
    tick();
    drive(1'b1, addr_of(3, 20), 32'h20, 1'b0);
    checks++;
    if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL sw_first: gnt %b expected 1", data_gnt_o); end
    tick();
    drive(1'b1, addr_of(5, 21), 32'h21, 1'b0);
    checks++;
    if (data_gnt_o !== 1'b0 || outstanding_o !== 3'd1) begin
      errors++; $display("FAIL sw_stall: gnt %b cnt %0d expected 0 1", data_gnt_o, outstanding_o);
    end
    tick();
    drive(1'b1, addr_of(5, 21), 32'h21, 1'b1);
    checks++;
    if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL sw_rsp_cycle: gnt %b expected 0", data_gnt_o); end
    tick();
    drive(1'b1, addr_of(5, 21), 32'h21, 1'b0);
    checks++;
    if (data_gnt_o !== 1'b1 || outstanding_o !== 3'd0) begin
      errors++; $display("FAIL sw_accept: gnt %b cnt %0d expected 1 0", data_gnt_o, outstanding_o);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (data_req_o !== 16'h0020 || data_add_o !== addr_of(5, 21) || outstanding_o !== 3'd1) begin
      errors++; $display("FAIL sw_out: req %h add %h cnt %0d expected 0020 %h 1", data_req_o, data_add_o, outstanding_o, addr_of(5, 21));
    end
    drain(1);
  endtask

  task automatic test_full_with_rsp();
    data_gnt_i = '1;
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'b1, addr_of(3, 30 + i), 32'(i), 1'b0);
    end
    tick();
    drive(1'b1, addr_of(3, 40), 32'h40, 1'b1);
    checks++;
    if (data_gnt_o !== 1'b0 || outstanding_o !== 3'd4) begin
      errors++; $display("FAIL full_rsp: gnt %b cnt %0d expected 0 4", data_gnt_o, outstanding_o);
    end
    tick();
    drive(1'b1, addr_of(3, 40), 32'h40, 1'b0);
    checks++;
    if (data_gnt_o !== 1'b1 || outstanding_o !== 3'd3) begin
      errors++; $display("FAIL full_next: gnt %b cnt %0d expected 1 3", data_gnt_o, outstanding_o);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (outstanding_o !== 3'd4 || data_add_o !== addr_of(3, 40)) begin
      errors++; $display("FAIL full_refill: cnt %0d add %h expected 4 %h", outstanding_o, data_add_o, addr_of(3, 40));
    end
    drain(4);
  endtask

  task automatic test_unexpected_rsp();
    tick();
    drive(1'b0, '0, '0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (outstanding_o !== 3'd0 || err_unexp_rsp_o !== 1'b1) begin
      errors++; $display("FAIL unexp: cnt %0d err %b expected 0 1", outstanding_o, err_unexp_rsp_o);
    end
    tick(); tick(); tick();
    checks++;
    if (err_unexp_rsp_o !== 1'b1) begin errors++; $display("FAIL unexp_sticky: err %b expected 1", err_unexp_rsp_o); end
  endtask

  task automatic test_reset_midflight();
    data_gnt_i = '1;
    tick();
    drive(1'b1, addr_of(3, 50), 32'h50, 1'b0);
    tick();
    drive(1'b1, addr_of(3, 51), 32'h51, 1'b0);
    tick();
    data_gnt_i = '0;
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (outstanding_o !== 3'd2 || data_req_o !== 16'h0008) begin
      errors++; $display("FAIL rst_pre: cnt %0d req %h expected 2 0008", outstanding_o, data_req_o);
    end
    rst = 1'b1;
    drive(1'b1, addr_of(3, 52), 32'h52, 1'b0);
    checks++;
    if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt: gnt %b expected 0", data_gnt_o); end
    tick();
    #2;
    checks++;
    if (data_req_o !== 16'h0 || outstanding_o !== 3'd0 || data_gnt_o !== 1'b0 || err_unexp_rsp_o !== 1'b0) begin
      errors++; $display("FAIL rst_post: req %h cnt %0d gnt %b err %b expected 0000 0 0 0",
                         data_req_o, outstanding_o, data_gnt_o, err_unexp_rsp_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL rst_release: gnt %b expected 1", data_gnt_o); end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (outstanding_o !== 3'd1 || data_add_o !== addr_of(3, 52)) begin
      errors++; $display("FAIL rst_after: cnt %0d add %h expected 1 %h", outstanding_o, data_add_o, addr_of(3, 52));
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold();
    test_switch();
    test_full_with_rsp();
    test_unexpected_rsp();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
